// File: rtl/psum_accum_requant_if.sv
// Stream bundle between the output aligner, the requantiser and the activation write-back stage.
// The master modport is the environment side; the slave modport is the requantiser.
interface psum_accum_requant_if #(
    parameter int LANES = 8,
    parameter int IW    = 18,
    parameter int OW    = 8
);
    logic                  i_valid;
    logic [LANES*IW-1:0]   i_data;
    logic                  o_valid;
    logic                  o_ready;
    logic [LANES*OW-1:0]   o_data;
    logic                  o_ovf;
    logic                  busy;
    logic                  err;

    modport master (
        output i_valid, i_data, o_ready,
        input  o_valid, o_data, o_ovf, busy, err
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output o_valid, o_data, o_ovf, busy, err
    );
endinterface

// File: rtl/psum_accum_requant.sv
// Accumulates TILES partial-sum vectors per lane, then applies ReLU, shift and unsigned clipping.
// Results queue in a 2-entry FIFO toward write-back; a full FIFO drops the result and sets a sticky error.
module psum_accum_requant #(
    parameter int LANES = 8,
    parameter int IW    = 18,
    parameter int AW    = 24,
    parameter int OW    = 8,
    parameter int TILES = 4,
    parameter int SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    psum_accum_requant_if.slave  bus
);
    localparam int            CW   = (TILES > 1) ? $clog2(TILES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILES - 1);

    logic [AW-1:0]        acc_r [LANES];
    logic [CW-1:0]        tile_cnt_r;
    logic                 grp_sat_r;

    logic [AW:0]          ext_s  [LANES];
    logic [AW:0]          wide_s [LANES];
    logic [AW-1:0]        sum_s  [LANES];
    logic [AW-1:0]        r_s    [LANES];
    logic [LANES-1:0]     sat_s;
    logic [LANES-1:0]     clip_s;
    logic [LANES*OW-1:0]  out_s;
    logic                 last_s;
    logic                 push_s;
    logic                 push_ok_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 ovf_s;

    logic [LANES*OW-1:0]  data_mem_r [2];
    logic                 ovf_mem_r  [2];
    logic                 rd_ptr_r;
    logic                 wr_ptr_r;
    logic [1:0]           count_r;
    logic                 err_r;

    // Per-lane saturating add and requantisation of the running sum.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            ext_s[k]  = {{(AW+1-IW){bus.i_data[k*IW+IW-1]}}, bus.i_data[k*IW +: IW]};
            wide_s[k] = {acc_r[k][AW-1], acc_r[k]} + ext_s[k];
            sat_s[k]  = 1'b0;
            if (tile_cnt_r == '0) begin
                sum_s[k] = ext_s[k][AW-1:0];
            end else if (wide_s[k][AW] != wide_s[k][AW-1]) begin
                // Overflow out of the signed AW range: clamp toward the sign of the true sum.
                sat_s[k] = 1'b1;
                sum_s[k] = wide_s[k][AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                sum_s[k] = wide_s[k][AW-1:0];
            end
            r_s[k]    = sum_s[k][AW-1] ? {AW{1'b0}} : (sum_s[k] >> SHIFT);
            clip_s[k] = |r_s[k][AW-1:OW];
            out_s[k*OW +: OW] = clip_s[k] ? {OW{1'b1}} : r_s[k][OW-1:0];
        end
    end

    // Group completion, FIFO handshake decisions and the overflow flag of the finishing group.
    always_comb begin
        last_s    = (tile_cnt_r == LAST);
        push_s    = bus.i_valid && last_s;
        pop_s     = (count_r != 2'd0) && bus.o_ready;
        push_ok_s = push_s && ((count_r != 2'd2) || pop_s);
        drop_s    = push_s && (count_r == 2'd2) && !pop_s;
        ovf_s     = (|clip_s) || (|sat_s) || (grp_sat_r && (tile_cnt_r != '0));
    end

    // Tile counter, accumulators and the group-wide saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt_r <= '0;
            grp_sat_r  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_r[k] <= '0;
            end
        end else if (bus.i_valid) begin
            if (last_s) begin
                tile_cnt_r <= '0;
                grp_sat_r  <= 1'b0;
            end else begin
                tile_cnt_r <= tile_cnt_r + CW'(1);
                grp_sat_r  <= (grp_sat_r && (tile_cnt_r != '0)) || (|sat_s);
                for (int k = 0; k < LANES; k++) begin
                    acc_r[k] <= sum_s[k];
                end
            end
        end
    end

    // Two-entry result FIFO; when full, a simultaneous pop frees the slot the push reuses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_mem_r[0] <= '0;
            data_mem_r[1] <= '0;
            ovf_mem_r[0]  <= 1'b0;
            ovf_mem_r[1]  <= 1'b0;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
            err_r         <= 1'b0;
        end else begin
            if (push_ok_s) begin
                data_mem_r[wr_ptr_r] <= out_s;
                ovf_mem_r[wr_ptr_r]  <= ovf_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (push_ok_s && !pop_s) begin
                count_r <= count_r + 2'd1;
            end else if (!push_ok_s && pop_s) begin
                count_r <= count_r - 2'd1;
            end
            err_r <= err_r || drop_s;
        end
    end

    assign bus.o_valid = (count_r != 2'd0);
    assign bus.o_data  = data_mem_r[rd_ptr_r];
    assign bus.o_ovf   = ovf_mem_r[rd_ptr_r];
    assign bus.busy    = (tile_cnt_r != '0);
    assign bus.err     = err_r;
endmodule

// File: tb/tb_psum_accum_requant.sv
// Directed bench for psum_accum_requant: accumulation, ReLU/shift/clip and FIFO drop/ordering.
module tb_psum_accum_requant;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    psum_accum_requant_if #(.LANES(8), .IW(18), .OW(8)) bus ();

    psum_accum_requant #(
        .LANES(8), .IW(18), .AW(24), .OW(8), .TILES(4), .SHIFT(6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] vec1(input int lane, input int val);
        logic [143:0] v;
        v = '0;
        v[lane*18 +: 18] = val[17:0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [143:0] v);
        bus.i_valid = 1'b1;
        bus.i_data  = v;
        tick();
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
    endtask

    task automatic send_group(input int lane0_val);
        for (int t = 0; t < 4; t++) begin
            send(vec1(0, lane0_val));
        end
    endtask

    task automatic pop_one();
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;
        tick();
        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_o_data",  bus.o_data,       64'd0);
        check("rst_o_ovf",   64'(bus.o_ovf),   64'd0);
        check("rst_busy",    64'(bus.busy),    64'd0);
        check("rst_err",     64'(bus.err),     64'd0);
        rst_n = 1'b1;
        tick();

        // T1: 100+200+300+400 = 1000, >>6 = 15, with idle cycles between valids
        send(vec1(0, 100)); tick();
        check("t1_busy", 64'(bus.busy), 64'd1);
        send(vec1(0, 200)); tick();
        send(vec1(0, 300)); tick(); tick();
        check("t1_no_early_valid", 64'(bus.o_valid), 64'd0);
        send(vec1(0, 400));
        check("t1_o_valid", 64'(bus.o_valid), 64'd1);
        check("t1_data",    bus.o_data,       64'h0F);
        check("t1_ovf",     64'(bus.o_ovf),   64'd0);
        check("t1_busy_end", 64'(bus.busy),   64'd0);
        pop_one();
        check("t1_drained", 64'(bus.o_valid), 64'd0);

        // T2: lane1 -200 -> 0; lane3 63>>6 -> 0; lane0 256>>6 -> 4
        send(vec1(0, 64) | vec1(1, -50) | vec1(3, 63));
        for (int t = 0; t < 3; t++) send(vec1(0, 64) | vec1(1, -50));
        check("t2_data", bus.o_data,     64'h04);
        check("t2_ovf",  64'(bus.o_ovf), 64'd0);
        pop_one();

        // T3: lane2 4*131071 = 524284, >>6 = 8191 -> clipped to 255
        for (int t = 0; t < 4; t++) send(vec1(2, 131071));
        check("t3_data", bus.o_data,     64'h0000_0000_00FF_0000);
        check("t3_ovf",  64'(bus.o_ovf), 64'd1);
        pop_one();

        // T4: groups A=4, B=8, C=12 back-to-back with no consumer; C is dropped
        send_group(64);
        send_group(128);
        check("t4_err_before_drop", 64'(bus.err), 64'd0);
        send_group(192);
        check("t4_err",    64'(bus.err), 64'd1);
        check("t4_head_a", bus.o_data,   64'h04);
        bus.o_ready = 1'b1;
        tick();
        check("t4_valid_b", 64'(bus.o_valid), 64'd1);
        check("t4_head_b",  bus.o_data,       64'h08);
        tick();
        check("t4_empty",   64'(bus.o_valid), 64'd0);
        check("t4_err_sticky", 64'(bus.err),  64'd1);
        bus.o_ready = 1'b0;

        // T5: FIFO full, last tile of C coincides with a pop -> no drop, order A,B,C
        do_reset();
        check("t5_err_cleared", 64'(bus.err), 64'd0);
        send_group(64);
        send_group(128);
        for (int t = 0; t < 3; t++) send(vec1(0, 192));
        bus.o_ready = 1'b1;
        send(vec1(0, 192));
        check("t5_err",    64'(bus.err),     64'd0);
        check("t5_head_b", bus.o_data,       64'h08);
        tick();
        check("t5_head_c", bus.o_data,       64'h0C);
        check("t5_valid_c", 64'(bus.o_valid), 64'd1);
        tick();
        check("t5_empty",  64'(bus.o_valid), 64'd0);
        bus.o_ready = 1'b0;

        // T6: reset after 2 of 4 tiles; next group must exclude the pre-reset sums
        send(vec1(0, 1000));
        send(vec1(0, 1000));
        check("t6_busy_mid", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_rst",  64'(bus.busy),    64'd0);
        check("t6_valid_rst", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_group(64);
        check("t6_valid", 64'(bus.o_valid), 64'd1);
        check("t6_data",  bus.o_data,       64'h04);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
